// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - store-port and status bundle of the buffered UART transmitter
interface uart_tx_buffered_if;
  logic [31:0] din;
  logic        we;
  logic        txd;
  logic        busy;
  logic        full;
  logic [15:0] drop_count;

  modport master (output din, output we, input txd, input busy, input full, input drop_count);
  modport slave  (input din, input we, output txd, output busy, output full, output drop_count);
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter, LSB first, fixed baud divider
module uart_tx_buffered #(
  parameter int CLK_DIV         = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_buffered_if.slave  bus
);
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0]          BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0]          BAUD_ONE  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]           CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 shift_q, shift_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic                       txd_q, txd_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]                drop_q, drop_d;
  logic [7:0]                 mem_q [DEPTH];

  logic empty, full, push, pop, baud_done;
  logic unused_din;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign push       = bus.we & ~full;
  assign baud_done  = (baud_q == BAUD_LAST);
  assign unused_din = ^bus.din[31:8];

  // FIFO bookkeeping; admission uses the full flag from the start of the cycle
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (!push && pop) count_d = count_q - CNT_ONE;
    drop_d = drop_q;
    if (bus.we && full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // back-to-back frames: next start bit follows the stop bit directly
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.din[7:0];
  end

  assign bus.txd        = txd_q;
  assign bus.busy       = (count_q != '0) | (state_q != IDLE);
  assign bus.full       = full;
  assign bus.drop_count = drop_q;
endmodule
